// File: rtl/wb_pkg.sv
// wb_pkg: write-back select encodings and HI/LO write-enable bit positions
package wb_pkg;
  typedef enum logic [2:0] {
    WB_ALU  = 3'd0,
    WB_LOAD = 3'd1,
    WB_LINK = 3'd2,
    WB_HI   = 3'd3,
    WB_LO   = 3'd4
  } wb_sel_e;
  localparam int HILO_HI = 1;
  localparam int HILO_LO = 0;
endpackage

// File: rtl/hilo_regs.sv
// hilo_regs: architectural HI/LO storage; clk/rst, en gates hilo_write, data[63:32]->hi, data[31:0]->lo
module hilo_regs
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  hilo_write,
  input  logic [63:0] data,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (en) begin
      if (hilo_write[HILO_HI]) hi <= data[63:32];
      if (hilo_write[HILO_LO]) lo <= data[31:0];
    end
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, write-data mux to regfile/forwarding, HI/LO and retire counter
module writeback_stage
  import wb_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Stall,
  input  logic                Flush,
  input  logic                Valid_in,
  input  logic                RegWrite_in,
  input  logic [2:0]          WBSel_in,
  input  logic [4:0]          WriteReg_in,
  input  logic [31:0]         ALUResult_in,
  input  logic [31:0]         LoadData_in,
  input  logic [31:0]         PCAdder_in,
  input  logic [1:0]          HiLoWrite_in,
  input  logic [63:0]         HiLoData_in,
  output logic                RegWrite_WB,
  output logic [4:0]          WriteReg_WB,
  output logic [31:0]         WriteData_WB,
  output logic                Valid_WB,
  output logic [31:0]         HI_out,
  output logic [31:0]         LO_out,
  output logic [RETIRE_W-1:0] RetireCount
);
  logic          valid_q, reg_write_q, retire;
  logic [2:0]    sel_q;
  logic [4:0]    reg_q;
  logic [31:0]   alu_q, load_q, link_q;
  assign retire = !Flush && !Stall && Valid_in;
  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      sel_q       <= '0;
      reg_q       <= '0;
      alu_q       <= '0;
      load_q      <= '0;
      link_q      <= '0;
    end else if (!Stall) begin
      valid_q     <= Valid_in;
      reg_write_q <= RegWrite_in;
      sel_q       <= WBSel_in;
      reg_q       <= WriteReg_in;
      alu_q       <= ALUResult_in;
      load_q      <= LoadData_in;
      link_q      <= PCAdder_in;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) RetireCount <= '0;
    else if (retire) RetireCount <= RetireCount + RETIRE_W'(1);
  end
  hilo_regs u_hilo (
    .clk       (Clk),
    .rst       (Reset),
    .en        (retire),
    .hilo_write(HiLoWrite_in),
    .data      (HiLoData_in),
    .hi        (HI_out),
    .lo        (LO_out)
  );
  always_comb begin
    WriteData_WB = sel_q == WB_ALU  ? alu_q  :
                   sel_q == WB_LOAD ? load_q :
                   sel_q == WB_LINK ? link_q :
                   sel_q == WB_HI   ? HI_out :
                   sel_q == WB_LO   ? LO_out : '0;
  end
  assign RegWrite_WB = valid_q && reg_write_q && (reg_q != '0);
  assign WriteReg_WB = reg_q;
  assign Valid_WB    = valid_q;
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage: MEM/WB pipeline register plus write-back selection. Captures the memory stage's results (ALU result, load data already sign-extended and selected, link address) with the register-file control bits, then drives the register-file write port and the forwarding bus. Also owns the architectural HI/LO registers and a retired-instruction counter. Sits directly downstream of the memory stage, feeding the register file in the decode stage.

## Interface
Parameters:
- `RETIRE_W`, 32, width of the retired-instruction counter.

Ports:
- Clock and reset: one clock, `Clk`; reset `Reset` is synchronous and active-high.
- `Clk`  in  1  clock
- `Reset`  in  1  synchronous active-high reset
- `Stall`  in  1  hold MEM/WB contents this cycle
- `Flush`  in  1  load a bubble this cycle; has priority over `Stall`
- `Valid_in`  in  1  memory stage holds a real instruction
- `RegWrite_in`  in  1  instruction writes a GPR
- `WBSel_in`  in  3  write-data source select
- `WriteReg_in`  in  5  destination GPR
- `ALUResult_in`  in  32  ALU result from EX/MEM
- `LoadData_in`  in  32  load-mux output of memory stage
- `PCAdder_in`  in  32  PC+4 of the instruction (link value)
- `HiLoWrite_in`  in  2  bit1 writes HI, bit0 writes LO
- `HiLoData_in`  in  64  [63:32] to HI, [31:0] to LO
- `RegWrite_WB`  out  1  register-file write enable
- `WriteReg_WB`  out  5  register-file write address
- `WriteData_WB`  out  32  register-file write data, also the forwarding value
- `Valid_WB`  out  1  WB stage holds a real instruction
- `HI_out`, `LO_out`  out  32 each  architectural HI/LO
- `RetireCount`  out  `RETIRE_W`  count of instructions captured into WB

## Operation
- One action per rising `Clk`, in priority order:
  - **Reset:** payload registers, `Valid_WB`, HI, LO and `RetireCount` go to 0.
  - **Flush:** load a bubble: Valid=0, RegWrite=0, WBSel=0, WriteReg=0, data fields 0. No HI/LO write, no count.
  - **Stall:** all registers hold, including HI, LO and the counter.
  - **Otherwise:** capture all `*_in` fields.
    - If `Valid_in`=1: write HI/LO as selected by `HiLoWrite_in` (the two bits are independent), and increment `RetireCount`.
    - If `Valid_in`=0: capture the payload but block HI/LO writes and the increment.
- `RegWrite_WB` = registered Valid & registered RegWrite & (registered WriteReg != 0). Register $0 is never written.
- `WriteData_WB` is combinational from the registered fields:
  - 0: ALU result
  - 1: load data
  - 2: PC+4 (link)
  - 3: HI
  - 4: LO
  - 5–7: 0
- `RetireCount` wraps from all-ones to 0 with no flag.
- Simultaneous MTHI capture and MFHI in WB: the MFHI in WB reads the old HI, because the HI update lands on the same edge.

## Timing
- Latency: 1 cycle from `*_in` to `*_WB`.
- HI/LO are visible on `HI_out`/`LO_out`, and to WBSel 3/4, in the cycle after the capturing edge.
- A back-to-back MTHI then MFHI returns the new value with no extra stall.
- No combinational path from any `*_in` to any output.
- `Stall` and `Flush` are sampled only at the edge. `Reset` overrides both.
- Reset mid-stall: everything clears and stall state is not retained.

## Structure
- Shared package `wb_pkg`:
  - WBSel encodings: `WB_ALU`=0, `WB_LOAD`=1, `WB_LINK`=2, `WB_HI`=3, `WB_LO`=4.
  - HiLoWrite bit positions.
- Sub-module `hilo_regs`:
  - HI/LO storage with enable, `HiLoWrite` and 64-bit data.
  - Synchronous reset to 0.
- Everything else lives in the top: MEM/WB register, write-data mux, retire counter.

## Test plan
- Reset high for 2 cycles with random inputs: all outputs 0. Release with Valid_in=1, RegWrite=1, WriteReg=5, WBSel=0, ALU=0x1234 → next cycle `RegWrite_WB`=1, `WriteReg_WB`=5, `WriteData_WB`=0x00001234, `RetireCount`=1.
- WriteReg=0, RegWrite=1 → `RegWrite_WB`=0. WBSel=1, LoadData=0xFFFFFF80 → `WriteData_WB`=0xFFFFFF80. WBSel=2, PCAdder=0x40 → 0x40.
- HiLoWrite=2'b11, HiLoData=0xAAAA0000_0000BBBB, then next cycle WBSel=3 → `WriteData_WB`=0xAAAA0000 with `HI_out` updated; then WBSel=4 → 0x0000BBBB.
- Stall held 3 cycles while inputs change → outputs, HI/LO and `RetireCount` all unchanged. Stall and Flush together → bubble: `Valid_WB`=0, `RegWrite_WB`=0, count unchanged.
- Valid_in=0 with HiLoWrite=2'b01 → LO unchanged, count unchanged.
- Preload `RetireCount`=0xFFFFFFFF (force or long run), then one valid instruction → `RetireCount`=0.
